// File: rtl/mul_pipe_if.sv
// -----------------------------------------------------------------------------
// mul_pipe_if
// Request/response bundle for the pipelined RV multiplier.
//   request : in_valid/in_ready handshake, in_op, in_rs1, in_rs2,
//             in_rd_addr, in_tag, in_instr, flush
//   response: out_valid/out_ready handshake, out_data, out_rd_addr,
//             out_rd_wr_en, out_tag, out_instr, busy
// Modports:
//   master - the issuing side (decode / testbench)
//   slave  - the multiplier itself
// -----------------------------------------------------------------------------
interface mul_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [4:0]       in_rd_addr;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [4:0]       out_rd_addr;
  logic             out_rd_wr_en;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      out_instr;
  logic             busy;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd_addr, in_tag, in_instr,
           flush, out_ready,
    input  in_ready, out_valid, out_data, out_rd_addr, out_rd_wr_en,
           out_tag, out_instr, busy
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd_addr, in_tag, in_instr,
           flush, out_ready,
    output in_ready, out_valid, out_data, out_rd_addr, out_rd_wr_en,
           out_tag, out_instr, busy
  );
endinterface

// File: rtl/mul_pipe.sv
// -----------------------------------------------------------------------------
// mul_pipe
// Fully pipelined RV M-extension multiplier (MUL, MULH, MULHSU, MULHU) with
// valid/ready on both sides and bubble-collapsing stage advance.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - mul_pipe_if.slave (request, response, flush, busy)
//
// Parameters:
//   XLEN   - operand/result width
//   STAGES - pipeline depth, legal 2..6; accept-to-result latency in cycles
//   TAG_W  - instruction tag width
//
// Build option:
//   MUL_SKID_EN - adds a one-entry skid buffer after the last stage, which
//                 removes the combinational out_ready -> in_ready path and
//                 raises capacity to STAGES+1.
//
// Stage layout: S0 holds the extended operands, S1 the product (multiplier
// may be retimed across S1..S(STAGES-1)), the last stage selects the result.
// -----------------------------------------------------------------------------
module mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_pipe_if.slave bus
);

  localparam int LAST = STAGES - 1;
  localparam int PW   = 2 * XLEN;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef struct packed {
    logic [4:0]       rd_addr;
    logic [TAG_W-1:0] tag;
    logic [31:0]      instr;
  } meta_t;

  typedef struct packed {
    op_e   op;
    meta_t meta;
  } ctrl_t;

  logic [STAGES-1:0] valid_q, valid_d, load;
  ctrl_t             ctrl_q [STAGES];
  ctrl_t             ctrl_d [STAGES];
  logic [XLEN:0]     a_q, a_d, b_q, b_d;
  logic [PW-1:0]     prod_q [1:LAST];
  logic [PW-1:0]     prod_d [1:LAST];
  logic [PW-1:0]     a_ext, b_ext;
  logic [XLEN-1:0]   last_data;
  logic              last_go;   // last stage may hand its entry onward
  logic              accept;

  // A stage may load when it, or any stage downstream of it, has a hole, or
  // when the last stage is draining. This is the ripple of
  // "empty or advancing" written without a combinational self-reference.
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign load[k] = last_go | ~(&valid_q[LAST:k]);
  end

  assign bus.in_ready = load[0] & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  // S0: operand extension. rs1 is signed except for MULHU, rs2 is signed
  // only for MUL/MULH (op[1] clear).
  assign valid_d[0] = load[0] ? accept : valid_q[0];
  assign ctrl_d[0]  = load[0] ? ctrl_t'{op:   op_e'(bus.in_op),
                                        meta: meta_t'{rd_addr: bus.in_rd_addr,
                                                      tag:     bus.in_tag,
                                                      instr:   bus.in_instr}}
                              : ctrl_q[0];
  assign a_d = load[0] ? {bus.in_rs1[XLEN-1] & (bus.in_op != OP_MULHU), bus.in_rs1} : a_q;
  assign b_d = load[0] ? {bus.in_rs2[XLEN-1] & ~bus.in_op[1], bus.in_rs2} : b_q;

  // Only the low 2*XLEN bits of the (XLEN+1)x(XLEN+1) signed product are ever
  // selected, so sign-extending to 2*XLEN and multiplying modulo 2^(2*XLEN)
  // yields exactly those bits.
  assign a_ext = {{(PW-XLEN-1){a_q[XLEN]}}, a_q};
  assign b_ext = {{(PW-XLEN-1){b_q[XLEN]}}, b_q};

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    assign valid_d[k] = load[k] ? valid_q[k-1] : valid_q[k];
    assign ctrl_d[k]  = load[k] ? ctrl_q[k-1]  : ctrl_q[k];
    if (k == 1) begin : g_mul
      assign prod_d[k] = load[k] ? a_ext * b_ext : prod_q[k];
    end else begin : g_carry
      assign prod_d[k] = load[k] ? prod_q[k-1] : prod_q[k];
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every stage samples its neighbour's pre-edge value.
  // NOTE: data registers are reset as well as valids because the response
  // fields must read zero while in reset; flush only touches valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ctrl_q  <= '{default: '0};
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '{default: '0};
    end else begin
      valid_q <= bus.flush ? '0 : valid_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  assign last_data = (ctrl_q[LAST].op == OP_MUL) ? prod_q[LAST][XLEN-1:0]
                                                 : prod_q[LAST][PW-1:XLEN];

  meta_t out_meta;

`ifdef MUL_SKID_EN
  logic            skid_valid_q;
  logic [XLEN-1:0] skid_data_q;
  meta_t           skid_meta_q;

  // The last stage keeps moving while the skid is free: its entry either
  // leaves on out_ready or parks in the skid.
  assign last_go = ~skid_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_meta_q  <= '0;
    end else begin
      if (bus.flush)         skid_valid_q <= 1'b0;
      else if (skid_valid_q) skid_valid_q <= ~bus.out_ready;
      else                   skid_valid_q <= valid_q[LAST] & ~bus.out_ready;
      if (!skid_valid_q) begin
        skid_data_q <= last_data;
        skid_meta_q <= ctrl_q[LAST].meta;
      end
    end
  end

  assign bus.out_valid = skid_valid_q | valid_q[LAST];
  assign bus.out_data  = skid_valid_q ? skid_data_q : last_data;
  assign out_meta      = skid_valid_q ? skid_meta_q : ctrl_q[LAST].meta;
  assign bus.busy      = skid_valid_q | (|valid_q);
`else
  assign last_go       = bus.out_ready;
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_data  = last_data;
  assign out_meta      = ctrl_q[LAST].meta;
  assign bus.busy      = |valid_q;
`endif

  assign bus.out_rd_wr_en = bus.out_valid;
  assign bus.out_rd_addr  = out_meta.rd_addr;
  assign bus.out_tag      = out_meta.tag;
  assign bus.out_instr    = out_meta.instr;

endmodule

// File: tb/tb_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_mul_pipe
// Directed-vector bench for mul_pipe. The driver pushes the hand-computed
// result of every accepted op into a queue; a monitor on the falling edge
// compares every presented response with the queue head and pops it when
// out_ready completes the handshake.
// -----------------------------------------------------------------------------
module tb_mul_pipe;

  localparam int STAGES = 3;
`ifdef MUL_SKID_EN
  localparam int CAP = STAGES + 1;
`else
  localparam int CAP = STAGES;
`endif
  localparam int NV = 12;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] tag;
    logic [31:0] instr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  int   tag_ctr = 1;
  int   run_len = 0;
  int   max_run = 0;
  exp_t exp_q [$];

  // op, rs1, rs2 and the hand-computed result of each vector
  logic [1:0]  v_op  [NV] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01,
                              2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [31:0] v_rs1 [NV] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                              32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000003, 32'h00000000};
  logic [31:0] v_rs2 [NV] = '{32'h00000002, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h00000010, 32'h00000005, 32'h00000004, 32'h00000002,
                              32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] v_res [NV] = '{32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                              32'h23456780, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF,
                              32'h00000001, 32'h3FFFFFFF, 32'h00000001, 32'h00000000};

  mul_pipe_if #(.XLEN(32), .TAG_W(32)) bus ();

  mul_pipe #(.XLEN(32), .STAGES(STAGES), .TAG_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] instr_of(input int tag);
    return 32'h02000033 + 32'(tag) * 32'h1000;
  endfunction

  task automatic set_fields(input int idx);
    bus.in_op      = v_op[idx];
    bus.in_rs1     = v_rs1[idx];
    bus.in_rs2     = v_rs2[idx];
    bus.in_rd_addr = 5'(idx + 1);
    bus.in_tag     = 32'(tag_ctr);
    bus.in_instr   = instr_of(tag_ctr);
  endtask

  task automatic push_exp(input int idx);
    exp_t e;
    e.data  = v_res[idx];
    e.rd    = 5'(idx + 1);
    e.tag   = 32'(tag_ctr);
    e.instr = instr_of(tag_ctr);
    exp_q.push_back(e);
    tag_ctr++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int idx, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    set_fields(idx);
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(idx);
        done = 1'b1;
      end else if (waits == 50) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", waits);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Offers a new op every cycle for the given number of cycles.
  task automatic fill(input int cycles, output int acc);
    acc = 0;
    for (int c = 0; c < cycles; c++) begin
      set_fields(c % NV);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(c % NV);
        acc++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic measure(input int idx);
    int w;
    int cnt;
    send(idx, w);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.out_valid && cnt < 20);
    check("latency", cnt, STAGES);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: every presented response must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got tag %0h, required no output", bus.out_tag);
      end else begin
        check("out_fields", {bus.out_data, bus.out_rd_addr, bus.out_tag, bus.out_instr}, exp_q[0]);
        check("out_wr_en", bus.out_rd_wr_en, 1);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  initial begin
    int w;
    int acc;
    int cnt;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_rd_addr = '0;
    bus.in_tag     = '0;
    bus.in_instr   = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_fields", {bus.out_data, bus.out_rd_addr, bus.out_tag,
                             bus.out_instr, bus.out_rd_wr_en}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1);

    // Single op latency, then the signed/unsigned high-half cases
    measure(0);
    drain();
    send(1, w);
    send(2, w);
    send(3, w);
    drain();

    // Ten back-to-back ops: never stalled, ten consecutive results
    max_run = 0;
    for (int i = 0; i < 10; i++) begin
      send(i + 2, w);
      check("burst_in_ready_waits", w, 0);
    end
    drain();
    check("burst_run", max_run, 10);

    // Output stall: capacity reached, in_ready drops, nothing lost
    bus.out_ready = 1'b0;
    fill(8, acc);
    check("stall_accepts", acc, CAP);
    @(negedge clk);
    check("stall_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();

    // Flush a full pipe while the head is being consumed
    bus.out_ready = 1'b0;
    fill(8, acc);
    set_fields(0);
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 0);
    @(posedge clk);
    exp_q.delete();
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_out_valid", bus.out_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    measure(1);
    drain();

    // Reset in the middle of traffic
    bus.out_ready = 1'b0;
    send(4, w);
    send(5, w);
    send(6, w);
    cnt = 0;
    while (!bus.out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("pre_reset_out_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_out_fields", {bus.out_data, bus.out_rd_addr, bus.out_tag,
                                 bus.out_instr, bus.out_rd_wr_en}, 0);
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    measure(9);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
